// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit:
// RV32I width codes, FSM states and the fault check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  // Unknown width codes fault the same way as misalignment.
  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    unique case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return lo[0];
      F3_W:        return |lo;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// MEM-stage request/response and data-memory
// signals shared by the unit and its environment.
interface mem_access_unit_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_misaligned;
  logic             dmem_wen;
  logic [WIDTH-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_wdata;
  logic [WIDTH-1:0] dmem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, dmem_rdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_misaligned,
    output dmem_wen, dmem_addr, dmem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, dmem_rdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_misaligned,
    input  dmem_wen, dmem_addr, dmem_wdata
  );

endinterface

// File: rtl/ls_align.sv
// Byte-lane logic: store merge, load extract/extend
// and fault detection. Purely combinational.
module ls_align
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rword,
  output logic [WIDTH-1:0] merged,
  output logic [WIDTH-1:0] ldata,
  output logic             misaligned
);

  localparam logic [WIDTH-1:0] B_M = WIDTH'(8'hFF);
  localparam logic [WIDTH-1:0] H_M = WIDTH'(16'hFFFF);

  logic [4:0]       b_sh;
  logic [4:0]       h_sh;
  logic [WIDTH-1:0] rsh;
  logic [WIDTH-1:0] wsh;
  logic [WIDTH-1:0] mask;

  always_comb begin
    b_sh = {addr_lo, 3'b000};
    h_sh = {addr_lo[1], 4'b0000};
    rsh  = rword >> b_sh;
    wsh  = '0;
    mask = '0;
    ldata = '0;
    misaligned = is_misaligned(funct3, addr_lo);
    unique case (funct3)
      F3_B, F3_BU: begin
        mask = B_M << b_sh;
        wsh  = wdata << b_sh;
        ldata = {{(WIDTH-8){rsh[7] & ~funct3[2]}},
                 rsh[7:0]};
      end
      F3_H, F3_HU: begin
        mask = H_M << h_sh;
        wsh  = wdata << h_sh;
        ldata = {{(WIDTH-16){rsh[15] & ~funct3[2]}},
                 rsh[15:0]};
      end
      F3_W: begin
        mask  = '1;
        wsh   = wdata;
        ldata = rword;
      end
      default: begin
        mask  = '0;
        wsh   = '0;
        ldata = '0;
      end
    endcase
    merged = (rword & ~mask) | (wsh & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one request at a time,
// read-modify-write for sub-word stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [2:0]       f3_q, f3_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rword_q, rword_d;
  logic             rv_q, rv_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             mis_q, mis_d;

  logic             idle;
  logic [2:0]       al_f3;
  logic [1:0]       al_lo;
  logic [WIDTH-1:0] al_wdata;
  logic [WIDTH-1:0] al_rword;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] ldata;
  logic             mis;

  assign idle = (state_q == S_IDLE);

  // IDLE aligns the live request; later states
  // replay the values captured at accept.
  assign al_f3    = idle ? bus.req_funct3 : f3_q;
  assign al_lo    = idle ? bus.req_addr[1:0]
                         : addr_q[1:0];
  assign al_wdata = idle ? bus.req_wdata : wdata_q;
  assign al_rword = idle ? bus.dmem_rdata : rword_q;

  ls_align #(.WIDTH(WIDTH)) u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .wdata      (al_wdata),
    .rword      (al_rword),
    .merged     (merged),
    .ldata      (ldata),
    .misaligned (mis)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    rword_d = rword_q;
    rv_d    = 1'b0;
    rdata_d = '0;
    mis_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          f3_d    = bus.req_funct3;
          wdata_d = bus.req_wdata;
          rword_d = bus.dmem_rdata;
          if (mis) begin
            state_d = S_RESP;
            rv_d    = 1'b1;
            mis_d   = 1'b1;
          end else if (bus.req_we) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RESP;
            rv_d    = 1'b1;
            rdata_d = ldata;
          end
        end
      end
      S_WRITE: begin
        state_d = S_RESP;
        rv_d    = 1'b1;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.req_ready = rst_n & idle;
  assign bus.dmem_wen  = rst_n
                       & (state_q == S_WRITE);
  assign bus.dmem_addr = idle
    ? {bus.req_addr[WIDTH-1:2], 2'b00}
    : {addr_q[WIDTH-1:2], 2'b00};
  assign bus.dmem_wdata      = merged;
  assign bus.resp_valid      = rv_q;
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a
// 4 KiB word memory model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  logic [31:0] mem [0:1023];

  mem_access_unit_if #(.WIDTH(32)) bus ();

  mem_access_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.dmem_rdata = mem[bus.dmem_addr[11:2]];

  always @(posedge clk)
    if (bus.dmem_wen)
      mem[bus.dmem_addr[11:2]] <= bus.dmem_wdata;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  // Issue one request, hold valid only for the
  // accept cycle, then watch up to 4 cycles.
  task automatic xact(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output int          lat,
    output logic [31:0] rd,
    output logic        mis,
    output int          wens,
    output logic [31:0] waddr,
    output logic [31:0] wdat
  );
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    #1 chk("ready_idle", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; wens = 0; rd = '0; mis = 1'b0;
    waddr = '0; wdat = '0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (bus.dmem_wen) begin
        wens++;
        waddr = bus.dmem_addr;
        wdat  = bus.dmem_wdata;
      end
      if (bus.resp_valid) begin
        lat = i;
        rd  = bus.resp_rdata;
        mis = bus.resp_misaligned;
        break;
      end
    end
  endtask

  task automatic load(input string tag,
                      input logic [2:0] f3,
                      input logic [31:0] a,
                      input logic [31:0] exp);
    int lat, wens;
    logic [31:0] rd, wa, wdt;
    logic mis;
    xact(1'b0, f3, a, 32'h0, lat, rd, mis,
         wens, wa, wdt);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_data"}, rd, exp);
    chk({tag, "_mis"}, 32'(mis), 0);
    chk({tag, "_nowen"}, wens, 0);
  endtask

  task automatic fault(input string tag,
                       input logic we,
                       input logic [2:0] f3,
                       input logic [31:0] a);
    int lat, wens;
    logic [31:0] rd, wa, wdt;
    logic mis;
    xact(we, f3, a, 32'hBEEF, lat, rd, mis,
         wens, wa, wdt);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_mis"}, 32'(mis), 1);
    chk({tag, "_data"}, rd, 0);
    chk({tag, "_nowen"}, wens, 0);
  endtask

  task automatic store(input string tag,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [31:0] ew);
    int lat, wens;
    logic [31:0] rd, wa, wdt;
    logic mis;
    xact(1'b1, f3, a, wd, lat, rd, mis,
         wens, wa, wdt);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_wens"}, wens, 1);
    chk({tag, "_waddr"}, wa, {a[31:2], 2'b00});
    chk({tag, "_wdata"}, wdt, ew);
    chk({tag, "_mis"}, 32'(mis), 0);
    chk({tag, "_rdata"}, rd, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem['h100 >> 2] = 32'h8899AABB;
    mem['h200 >> 2] = 32'h11223344;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_valid", 32'(bus.resp_valid), 0);
    chk("rst_wen", 32'(bus.dmem_wen), 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_mis", 32'(bus.resp_misaligned), 0);
    rst_n = 1'b1;
    #1 chk("rel_ready", 32'(bus.req_ready), 1);

    bus.req_addr = 32'h103;
    #1 chk("idle_addr", bus.dmem_addr, 32'h100);

    load("lb",  3'b000, 32'h101, 32'hFFFFFFAA);
    load("lbu", 3'b100, 32'h101, 32'h000000AA);
    load("lb3", 3'b000, 32'h103, 32'hFFFFFF88);
    load("lh",  3'b001, 32'h102, 32'hFFFF8899);
    load("lhu", 3'b101, 32'h100, 32'h0000AABB);
    load("lw",  3'b010, 32'h100, 32'h8899AABB);

    store("sb", 3'b000, 32'h202, 32'h55,
          32'h11553344);
    chk("sb_mem", mem['h200 >> 2], 32'h11553344);
    store("sh", 3'b001, 32'h402, 32'hBEEF,
          32'hBEEF0000);
    load("lh_st", 3'b001, 32'h402, 32'hFFFFBEEF);

    fault("sh_mis", 1'b1, 3'b001, 32'h203);
    chk("sh_mis_mem", mem['h200 >> 2],
        32'h11553344);
    fault("f3_011", 1'b0, 3'b011, 32'h100);
    fault("lw_mis", 1'b0, 3'b010, 32'h102);

    // SW then LW held valid through RESP.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h300;
    bus.req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    #1 bus.req_we  = 1'b0;
    @(negedge clk);
    chk("b2b_wen", 32'(bus.dmem_wen), 1);
    chk("b2b_wdata", bus.dmem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("b2b_rv1", 32'(bus.resp_valid), 1);
    chk("b2b_nrdy", 32'(bus.req_ready), 0);
    @(negedge clk);
    chk("b2b_rdy", 32'(bus.req_ready), 1);
    chk("b2b_rv0", 32'(bus.resp_valid), 0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rv2", 32'(bus.resp_valid), 1);
    chk("b2b_ld", bus.resp_rdata, 32'hDEADBEEF);

    // Reset while the SB sits in WRITE.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h200;
    bus.req_wdata  = 32'h77;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("wr_rst_wen", 32'(bus.dmem_wen), 0);
    chk("wr_rst_rdy", 32'(bus.req_ready), 0);
    @(negedge clk);
    chk("ar_valid", 32'(bus.resp_valid), 0);
    chk("ar_rdata", bus.resp_rdata, 0);
    chk("ar_mis", 32'(bus.resp_misaligned), 0);
    chk("ar_wen", 32'(bus.dmem_wen), 0);
    chk("ar_mem", mem['h200 >> 2], 32'h11553344);
    rst_n = 1'b1;
    #1 chk("ar_ready", 32'(bus.req_ready), 1);
    load("lw_ar", 3'b010, 32'h200, 32'h11553344);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WIDTH, default 32, data and address width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req_valid  input  1  pipeline MEM-stage request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  WIDTH  byte address.
REQ-009 req_wdata  input  WIDTH  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle pulse: request complete.
REQ-011 resp_rdata  output  WIDTH  load result, extended to WIDTH; 0 for stores.
REQ-012 resp_misaligned  output  1  request faulted (misaligned or illegal funct3), valid with resp_valid.
REQ-013 dmem_wen  output  1  word write enable to the data memory.
REQ-014 dmem_addr  output  WIDTH  word-aligned byte address to the data memory (bits [1:0] = 0).
REQ-015 dmem_wdata  output  WIDTH  full word written to the data memory.
REQ-016 dmem_rdata  input  WIDTH  combinational read data from the data memory at dmem_addr.

Function
REQ-017 The unit SHALL implement FSM states IDLE, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, dmem_addr SHALL equal {req_addr[WIDTH-1:2],2'b00}; in WRITE and RESP it SHALL equal the latched word address.
REQ-019 Accept occurs when req_valid and req_ready are both 1; the unit SHALL latch the address, funct3, wdata and the dmem_rdata word in that cycle.
REQ-020 Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; funct3 011, 110 or 111 is illegal. Any of these SHALL go IDLE->RESP with resp_misaligned=1, resp_rdata=0 and no write.
REQ-021 An aligned load SHALL go IDLE->RESP; in RESP, resp_valid=1 and resp_rdata holds the selected byte/half/word, sign-extended for B/H and zero-extended for BU/HU/W.
REQ-022 An aligned store SHALL go IDLE->WRITE->RESP; in WRITE, dmem_wen=1 and dmem_wdata is the latched read word with only the addressed byte lanes replaced (SB: 1 lane selected by addr[1:0]; SH: lanes selected by addr[1]; SW: all 4 lanes).
REQ-023 dmem_wen SHALL be 1 only in WRITE with rst_n=1; it SHALL be 0 in every other cycle.
REQ-024 RESP SHALL last exactly one cycle and return to IDLE; resp_valid has no backpressure.
REQ-025 Latency: loads and faults SHALL pulse resp_valid 1 cycle after accept; stores 2 cycles after accept.
REQ-026 Back-to-back: a request accepted in the IDLE cycle after RESP SHALL observe every prior completed store, including a load to the same word.
REQ-027 resp_rdata and resp_misaligned SHALL be 0 whenever resp_valid=0.
REQ-028 Address arithmetic SHALL ignore bits above WIDTH; the unit SHALL perform no address range check.

Reset
REQ-029 While rst_n=0 at a rising edge, the state SHALL become IDLE and resp_valid, resp_rdata, resp_misaligned and all latched registers SHALL become 0.
REQ-030 dmem_wen SHALL be 0 in any cycle where rst_n=0, so a reset during WRITE aborts the store with no memory change.
REQ-031 req_ready SHALL be 0 while rst_n=0, and 1 in the first cycle after release.

Structure
REQ-032 A shared package mem_pkg SHALL hold the funct3 width encodings and the FSM state enumeration.
REQ-033 A combinational sub-module ls_align SHALL perform store lane merge, load extraction/extension and misalignment detection; the FSM and registers remain in mem_access_unit.

Verification
REQ-034 Memory word 0x100 = 0x8899AABB; LB at 0x101 -> 1 cycle later resp_valid=1, resp_rdata=0xFFFFFFAA; LBU at 0x101 -> 0x000000AA.
REQ-035 Word 0x200 = 0x11223344; SB 0x55 at 0x202 -> dmem_wen for exactly 1 cycle, dmem_addr=0x200, dmem_wdata=0x11553344; resp_valid 2 cycles after accept.
REQ-036 SH 0xBEEF at 0x203 -> resp_misaligned=1, resp_valid 1 cycle after accept, dmem_wen never 1; funct3=011 load -> same fault response.
REQ-037 SW 0xDEADBEEF at 0x300, then LW at 0x300 held valid -> load accepted in the IDLE cycle after RESP; resp_rdata=0xDEADBEEF.
REQ-038 Assert rst_n=0 during a WRITE cycle of SB at 0x200 -> dmem_wen=0 that cycle, memory unchanged, state IDLE, all outputs 0 after the edge.
